// File: rtl/watch_pkg.sv
// watch_pkg: field widths, FSM/field codes, limits and the wrap helper for watch_time_set.
// rev 1.0
`default_nettype none
package watch_pkg;
  localparam int YEAR_W  = 12;
  localparam int MONTH_W = 4;
  localparam int DAY_W   = 5;
  localparam int HMS_W   = 6;

  typedef logic [2:0] state_t;
  // State codes double as edit_field codes for the EDIT_* states.
  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_EDIT_HOUR  = 3'd1;
  localparam logic [2:0] S_EDIT_MIN   = 3'd2;
  localparam logic [2:0] S_EDIT_SEC   = 3'd3;
  localparam logic [2:0] S_EDIT_YEAR  = 3'd4;
  localparam logic [2:0] S_EDIT_MONTH = 3'd5;
  localparam logic [2:0] S_EDIT_DAY   = 3'd6;
  localparam logic [2:0] S_COMMIT     = 3'd7;

  localparam logic [2:0] FIELD_NONE = 3'd0;

  localparam int HOUR_MAX  = 23;
  localparam int MIN_MAX   = 59;
  localparam int SEC_MAX   = 59;
  localparam int MONTH_MIN = 1;
  localparam int MONTH_MAX = 12;
  localparam int DAY_MIN   = 1;

  // One +/-1 step with wrap; an out-of-range value snaps to the lower limit.
  function automatic logic [11:0] wrap_step(input logic [11:0] v, input logic inc,
                                            input logic [11:0] lo, input logic [11:0] hi);
    logic [11:0] r;
    r = v;
    if (v < lo || v > hi) r = lo;
    else if (inc)         r = (v == hi) ? lo : v + 12'd1;
    else                  r = (v == lo) ? hi : v - 12'd1;
    return r;
  endfunction
endpackage
`default_nettype wire

// File: rtl/button_repeat.sv
// button_repeat: rising-edge event generator with optional hold-then-repeat pulses.
// rev 1.0
`default_nettype none
module button_repeat #(
  parameter int HOLD_CYCLES   = 500,
  parameter int REPEAT_CYCLES = 100,
  parameter bit REPEAT_EN     = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);
  localparam int MAX_C = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CW    = $clog2(MAX_C + 1);
  localparam logic [CW-1:0] HOLD_C = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] REP_C  = CW'(REPEAT_CYCLES);

  logic          prev;
  logic          repeating;
  logic [CW-1:0] cnt;
  logic          rise;
  logic          fire;

  assign rise = level & ~prev;
  // cnt equals the number of cycles since the last edge or repeat pulse
  assign fire = REPEAT_EN && level && !rise && (cnt == (repeating ? REP_C : HOLD_C));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev      <= 1'b0;
      repeating <= 1'b0;
      cnt       <= '0;
      pulse     <= 1'b0;
    end else begin
      prev  <= level;
      pulse <= rise | fire;
      if (!level) begin
        cnt       <= '0;
        repeating <= 1'b0;
      end else if (rise) begin
        cnt       <= CW'(1);
        repeating <= 1'b0;
      end else if (fire) begin
        cnt       <= CW'(1);
        repeating <= 1'b1;
      end else if (cnt != '1) begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/watch_time_set.sv
// watch_time_set: button-driven time/date editor delivering one valid/ready load.
// rev 1.0
`default_nettype none
module watch_time_set
  import watch_pkg::*;
#(
  parameter int RESET_YEAR     = 2021,
  parameter int YEAR_MIN       = 2000,
  parameter int YEAR_MAX       = 2099,
  parameter int DAYS_PER_MONTH = 30,
  parameter int HOLD_CYCLES    = 500,
  parameter int REPEAT_CYCLES  = 100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_mode,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_cancel,
  input  logic [YEAR_W-1:0]  cur_year,
  input  logic [MONTH_W-1:0] cur_month,
  input  logic [DAY_W-1:0]   cur_day,
  input  logic [HMS_W-1:0]   cur_hour,
  input  logic [HMS_W-1:0]   cur_minute,
  input  logic [HMS_W-1:0]   cur_second,
  output logic [YEAR_W-1:0]  set_year,
  output logic [MONTH_W-1:0] set_month,
  output logic [DAY_W-1:0]   set_day,
  output logic [HMS_W-1:0]   set_hour,
  output logic [HMS_W-1:0]   set_minute,
  output logic [HMS_W-1:0]   set_second,
  output logic               set_valid,
  input  logic               set_ready,
  output logic               editing,
  output logic [2:0]         edit_field
);
  state_t state;
  logic   ev_mode, ev_up, ev_down, ev_cancel;
  logic   step;

  button_repeat #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES), .REPEAT_EN(1'b1))
    u_up     (.clk(clk), .rst(rst), .level(btn_up),     .pulse(ev_up));
  button_repeat #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES), .REPEAT_EN(1'b1))
    u_down   (.clk(clk), .rst(rst), .level(btn_down),   .pulse(ev_down));
  button_repeat #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES), .REPEAT_EN(1'b0))
    u_mode   (.clk(clk), .rst(rst), .level(btn_mode),   .pulse(ev_mode));
  button_repeat #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES), .REPEAT_EN(1'b0))
    u_cancel (.clk(clk), .rst(rst), .level(btn_cancel), .pulse(ev_cancel));

  // Simultaneous up and down cancel each other out
  assign step       = ev_up ^ ev_down;
  assign set_valid  = (state == S_COMMIT);
  assign editing    = (state != S_IDLE) && (state != S_COMMIT);
  assign edit_field = editing ? state : FIELD_NONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      set_year   <= YEAR_W'(RESET_YEAR);
      set_month  <= MONTH_W'(1);
      set_day    <= DAY_W'(1);
      set_hour   <= '0;
      set_minute <= '0;
      set_second <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ev_mode) begin
            set_year   <= cur_year;
            set_month  <= cur_month;
            set_day    <= cur_day;
            set_hour   <= cur_hour;
            set_minute <= cur_minute;
            set_second <= cur_second;
            state      <= S_EDIT_HOUR;
          end
        end
        S_COMMIT: begin
          if (set_ready) state <= S_IDLE;
        end
        default: begin
          if (ev_cancel) begin
            state <= S_IDLE;
          end else if (ev_mode) begin
            state <= state + 3'd1;
          end else if (step) begin
            case (state)
              S_EDIT_HOUR:  set_hour   <= HMS_W'(wrap_step(12'(set_hour), ev_up, 12'd0, 12'(HOUR_MAX)));
              S_EDIT_MIN:   set_minute <= HMS_W'(wrap_step(12'(set_minute), ev_up, 12'd0, 12'(MIN_MAX)));
              S_EDIT_SEC:   set_second <= HMS_W'(wrap_step(12'(set_second), ev_up, 12'd0, 12'(SEC_MAX)));
              S_EDIT_YEAR:  set_year   <= wrap_step(set_year, ev_up, 12'(YEAR_MIN), 12'(YEAR_MAX));
              S_EDIT_MONTH: set_month  <= MONTH_W'(wrap_step(12'(set_month), ev_up,
                                                             12'(MONTH_MIN), 12'(MONTH_MAX)));
              default:      set_day    <= DAY_W'(wrap_step(12'(set_day), ev_up,
                                                           12'(DAY_MIN), 12'(DAYS_PER_MONTH)));
            endcase
          end
        end
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_watch_time_set.sv
// tb_watch_time_set: table-driven checks of editing, wrap, handshake, repeat and reset.
// rev 1.0
`default_nettype none
module tb_watch_time_set;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_mode = 0, btn_up = 0, btn_down = 0, btn_cancel = 0;
  logic [11:0] cur_year = 0;
  logic [3:0]  cur_month = 0;
  logic [4:0]  cur_day = 0;
  logic [5:0]  cur_hour = 0, cur_minute = 0, cur_second = 0;
  logic [11:0] set_year;
  logic [3:0]  set_month;
  logic [4:0]  set_day;
  logic [5:0]  set_hour, set_minute, set_second;
  logic        set_valid;
  logic        set_ready = 1'b0;
  logic        editing;
  logic [2:0]  edit_field;

  int compared = 0;
  int mismatched = 0;
  int xfers = 0;
  int valid_cycles = 0;
  logic [11:0] xf_year;
  logic [5:0]  xf_hour, xf_minute, xf_second;

  localparam logic [3:0] B_NONE = 4'b0000, B_MODE = 4'b0001, B_UP = 4'b0010,
                         B_DOWN = 4'b0100, B_CANCEL = 4'b1000;

  typedef struct {
    logic [3:0] btn;
    int ef, ed, hour, minute, second, year, month, day, valid;
  } vec_t;

  vec_t va[10];
  vec_t vb[11];

  watch_time_set #(.HOLD_CYCLES(10), .REPEAT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down), .btn_cancel(btn_cancel),
    .cur_year(cur_year), .cur_month(cur_month), .cur_day(cur_day),
    .cur_hour(cur_hour), .cur_minute(cur_minute), .cur_second(cur_second),
    .set_year(set_year), .set_month(set_month), .set_day(set_day),
    .set_hour(set_hour), .set_minute(set_minute), .set_second(set_second),
    .set_valid(set_valid), .set_ready(set_ready),
    .editing(editing), .edit_field(edit_field)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (set_valid) valid_cycles++;
    if (set_valid && set_ready) begin
      xfers++;
      xf_year   <= set_year;
      xf_hour   <= set_hour;
      xf_minute <= set_minute;
      xf_second <= set_second;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_btn(input logic [3:0] b);
    {btn_cancel, btn_down, btn_up, btn_mode} = b;
  endtask

  // Level high for exactly one sampling edge, then settle
  task automatic press(input logic [3:0] b);
    @(negedge clk); set_btn(b);
    @(negedge clk); set_btn(B_NONE);
    repeat (3) @(negedge clk);
  endtask

  task automatic set_cur(input int y, input int mo, input int d, input int h, input int mi, input int s);
    cur_year = 12'(y); cur_month = 4'(mo); cur_day = 5'(d);
    cur_hour = 6'(h); cur_minute = 6'(mi); cur_second = 6'(s);
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    chk({tag, " edit_field"}, int'(edit_field), v.ef);
    chk({tag, " editing"},    int'(editing),    v.ed);
    chk({tag, " hour"},       int'(set_hour),   v.hour);
    chk({tag, " minute"},     int'(set_minute), v.minute);
    chk({tag, " second"},     int'(set_second), v.second);
    chk({tag, " year"},       int'(set_year),   v.year);
    chk({tag, " month"},      int'(set_month),  v.month);
    chk({tag, " day"},        int'(set_day),    v.day);
    chk({tag, " valid"},      int'(set_valid),  v.valid);
  endtask

  initial begin
    int x0, vc0;
    logic [11:0] snap_year;
    logic [5:0]  snap_hour, snap_minute, snap_second;

    //         btn       ef ed  h   m   s   year  mo  d  v
    va[0] = '{B_UP,      0, 0,  0,  0,  0, 2021,  1,  1, 0};
    va[1] = '{B_CANCEL,  0, 0,  0,  0,  0, 2021,  1,  1, 0};
    va[2] = '{B_MODE,    1, 1, 23, 59, 58, 2021,  3, 15, 0};
    va[3] = '{B_UP,      1, 1,  0, 59, 58, 2021,  3, 15, 0};
    va[4] = '{B_MODE,    2, 1,  0, 59, 58, 2021,  3, 15, 0};
    va[5] = '{B_UP,      2, 1,  0,  0, 58, 2021,  3, 15, 0};
    va[6] = '{B_MODE,    3, 1,  0,  0, 58, 2021,  3, 15, 0};
    va[7] = '{B_MODE,    4, 1,  0,  0, 58, 2021,  3, 15, 0};
    va[8] = '{B_MODE,    5, 1,  0,  0, 58, 2021,  3, 15, 0};
    va[9] = '{B_MODE,    6, 1,  0,  0, 58, 2021,  3, 15, 0};

    vb[0]  = '{B_MODE,          1, 1, 10, 20, 30, 2000,  1, 30, 0};
    vb[1]  = '{B_MODE,          2, 1, 10, 20, 30, 2000,  1, 30, 0};
    vb[2]  = '{B_MODE,          3, 1, 10, 20, 30, 2000,  1, 30, 0};
    vb[3]  = '{B_MODE,          4, 1, 10, 20, 30, 2000,  1, 30, 0};
    vb[4]  = '{B_DOWN,          4, 1, 10, 20, 30, 2099,  1, 30, 0};
    vb[5]  = '{B_MODE,          5, 1, 10, 20, 30, 2099,  1, 30, 0};
    vb[6]  = '{B_DOWN,          5, 1, 10, 20, 30, 2099, 12, 30, 0};
    vb[7]  = '{B_UP | B_DOWN,   5, 1, 10, 20, 30, 2099, 12, 30, 0};
    vb[8]  = '{B_MODE,          6, 1, 10, 20, 30, 2099, 12, 30, 0};
    vb[9]  = '{B_UP,            6, 1, 10, 20, 30, 2099, 12,  1, 0};
    vb[10] = '{B_CANCEL|B_MODE, 0, 0, 10, 20, 30, 2099, 12,  1, 0};

    @(negedge clk);
    check_vec("reset", '{B_NONE, 0, 0, 0, 0, 0, 2021, 1, 1, 0});
    @(negedge clk); rst = 1'b0;

    // Full edit up to the day field
    set_cur(2021, 3, 15, 23, 59, 58);
    for (int i = 0; i < 10; i++) begin
      press(va[i].btn);
      check_vec($sformatf("va%0d", i), va[i]);
    end

    // COMMIT with ready low while buttons churn
    press(B_MODE);
    chk("commit valid", int'(set_valid), 1);
    chk("commit editing", int'(editing), 0);
    snap_year = set_year; snap_hour = set_hour; snap_minute = set_minute; snap_second = set_second;
    x0 = xfers;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      set_btn(4'($urandom_range(0, 15)));
      chk("hold valid", int'(set_valid), 1);
      chk("hold data", int'({set_year, set_hour, set_minute, set_second}),
          int'({snap_year, snap_hour, snap_minute, snap_second}));
    end
    set_btn(B_NONE);
    repeat (3) @(negedge clk);
    chk("hold still valid", int'(set_valid), 1);
    chk("hold no transfer", xfers - x0, 0);
    set_ready = 1'b1;
    @(negedge clk); set_ready = 1'b0;
    chk("after accept valid", int'(set_valid), 0);
    chk("after accept field", int'(edit_field), 0);
    chk("one transfer", xfers - x0, 1);
    chk("xfer hour", int'(xf_hour), 0);
    chk("xfer minute", int'(xf_minute), 0);
    chk("xfer second", int'(xf_second), 58);
    chk("xfer year", int'(xf_year), 2021);
    repeat (3) @(negedge clk);
    chk("no second transfer", xfers - x0, 1);

    // Wrap limits, simultaneous events, cancel
    set_cur(2000, 1, 30, 10, 20, 30);
    x0 = xfers;
    for (int i = 0; i < 11; i++) begin
      press(vb[i].btn);
      check_vec($sformatf("vb%0d", i), vb[i]);
    end
    chk("cancel no transfer", xfers - x0, 0);

    // Ready high while idle, out-of-range capture, one-cycle valid
    set_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle ready no transfer", xfers - x0, 0);
    set_cur(2150, 1, 1, 0, 0, 0);
    repeat (4) press(B_MODE);
    chk("oor year captured", int'(set_year), 2150);
    press(B_UP);
    chk("oor year snap", int'(set_year), 2000);
    vc0 = valid_cycles;
    repeat (3) press(B_MODE);
    chk("fast commit transfers", xfers - x0, 1);
    chk("fast commit valid cycles", valid_cycles - vc0, 1);
    chk("fast commit year", int'(xf_year), 2000);
    chk("fast commit idle", int'(edit_field), 0);
    set_ready = 1'b0;

    // Auto-repeat: 30 held cycles in EDIT_MIN from 0
    set_cur(2021, 1, 1, 5, 0, 0);
    press(B_MODE);
    press(B_MODE);
    chk("repeat start field", int'(edit_field), 2);
    @(negedge clk); btn_up = 1'b1;
    repeat (30) @(negedge clk);
    btn_up = 1'b0;
    repeat (3) @(negedge clk);
    chk("repeat minute", int'(set_minute), 6);

    // Asynchronous reset mid-cycle
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_vec("async reset", '{B_NONE, 0, 0, 0, 0, 0, 2021, 1, 1, 0});
    @(negedge clk); rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
`default_nettype wire
